// File: rtl/scroll_seq_ctrl.sv
// Round-robin sequencer for the 3-digit scrolling display: grants a source, bursts its digits, scrolls, cleans.
// Optional build macro PRIORITY_PREEMPT_EN lets source A abort a B message while it is scrolling.
module scroll_seq_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int PASSES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [11:0] msg_a,
    input  logic        req_b,
    input  logic [11:0] msg_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        o_rd,
    output logic [3:0]  o_dec,
    output logic        o_div_clk,
    output logic        o_clean,
    output logic        busy,
    output logic        done
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   TICK_PRE  = PW'(TICK_DIV - 2);
    localparam logic [3:0]      PASS_LAST = 4'(PASSES);
    localparam logic [3:0]      BLANK     = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2,
        CLEAN = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    lcnt;
    logic [11:0]   msg_q;
    logic          owner_b;
    logic          last_b;
    logic [2:0]    step;
    logic [3:0]    pass;
    logic [PW-1:0] presc;
    logic          tick;
    logic          pick_b;
`ifdef PRIORITY_PREEMPT_EN
    logic          force_a;
`endif

    assign tick = (presc == TICK_LAST);

    // Prescaler and step counter run in every state; the step counter tracks the display position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            o_div_clk <= 1'b0;
            step      <= 3'd0;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            o_div_clk <= (presc == TICK_PRE);
            if (tick) begin
                if (o_clean || step == 3'd6)
                    step <= 3'd0;
                else
                    step <= step + 3'd1;
            end
        end
    end

    always_comb begin
        if (req_a && req_b)
            pick_b = ~last_b;
        else
            pick_b = req_b;
`ifdef PRIORITY_PREEMPT_EN
        if (force_a && req_a)
            pick_b = 1'b0;
`endif
    end

    // The cycle carrying done is skipped by arbitration, so a waiting request lands in L0 two cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lcnt    <= 2'd0;
            msg_q   <= 12'h000;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            pass    <= 4'd0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            o_rd    <= 1'b0;
            o_dec   <= BLANK;
            o_clean <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PRIORITY_PREEMPT_EN
            force_a <= 1'b0;
`endif
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!done && (req_a || req_b)) begin
                        state   <= LOAD;
                        lcnt    <= 2'd0;
                        msg_q   <= pick_b ? msg_b : msg_a;
                        owner_b <= pick_b;
                        last_b  <= pick_b;
                        gnt_a   <= ~pick_b;
                        gnt_b   <= pick_b;
                        o_rd    <= 1'b1;
                        o_dec   <= BLANK;
                        busy    <= 1'b1;
`ifdef PRIORITY_PREEMPT_EN
                        force_a <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    lcnt <= lcnt + 2'd1;
                    // Digits trail the strobe by one cycle to line up with the display's registered write enable.
                    case (lcnt)
                        2'd0: begin
                            o_rd  <= 1'b1;
                            o_dec <= msg_q[11:8];
                        end
                        2'd1: begin
                            o_rd  <= 1'b1;
                            o_dec <= msg_q[7:4];
                        end
                        2'd2: begin
                            o_rd  <= 1'b0;
                            o_dec <= msg_q[3:0];
                        end
                        default: begin
                            o_rd  <= 1'b0;
                            o_dec <= BLANK;
                            pass  <= 4'd0;
                            state <= SHOW;
                        end
                    endcase
                end
                SHOW: begin
`ifdef PRIORITY_PREEMPT_EN
                    if (owner_b && req_a) begin
                        state   <= CLEAN;
                        o_clean <= 1'b1;
                        force_a <= 1'b1;
                    end else
`endif
                    if (tick && step == 3'd6) begin
                        pass <= pass + 4'd1;
                        if (pass + 4'd1 == PASS_LAST) begin
                            state   <= CLEAN;
                            o_clean <= 1'b1;
                        end
                    end
                end
                CLEAN: begin
                    // The display only samples clean on the scroll tick, so hold it until then.
                    if (tick) begin
                        o_clean <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_seq_ctrl.sv
// Directed bench for scroll_seq_ctrl (TICK_DIV=4, PASSES=2) with a digit scoreboard and event logs.
module tb_scroll_seq_ctrl;

    localparam int TICK_DIV = 4;
    localparam int PASSES   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [11:0] msg_a = 12'h000;
    logic [11:0] msg_b = 12'h000;
    logic        gnt_a, gnt_b, o_rd, o_div_clk, o_clean, busy, done;
    logic [3:0]  o_dec;

    scroll_seq_ctrl #(.TICK_DIV(TICK_DIV), .PASSES(PASSES)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .msg_a     (msg_a),
        .req_b     (req_b),
        .msg_b     (msg_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .o_rd      (o_rd),
        .o_dec     (o_dec),
        .o_div_clk (o_div_clk),
        .o_clean   (o_clean),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc;
    int         first_clean;
    int         clean_n;
    int         rd_n;
    logic       prev_rd;
    logic       auto_drop;
    logic [3:0] exp_q[$];
    int         ga_q[$];
    int         gb_q[$];
    int         done_q[$];
    logic       busy_log[0:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic void push_msg(input logic [11:0] m);
        exp_q.push_back(m[11:8]);
        exp_q.push_back(m[7:4]);
        exp_q.push_back(m[3:0]);
    endfunction

    // Holds reset for two cycles and releases at a falling edge; that interval is cycle 0.
    task automatic do_reset();
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        cyc         = 0;
        prev_rd     = 1'b0;
        auto_drop   = 1'b1;
        first_clean = -1;
        clean_n     = 0;
        rd_n        = 0;
        exp_q.delete();
        ga_q.delete();
        gb_q.delete();
        done_q.delete();
        for (int i = 0; i < 256; i++) busy_log[i] = 1'b0;
        rst = 1'b1;
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_b", gnt_b, 0);
        check("rst_rd", o_rd, 0);
        check("rst_dec", o_dec, 4'hF);
        check("rst_div_clk", o_div_clk, 0);
        check("rst_clean", o_clean, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    // Advance one cycle, sample at the falling edge, score digits and the divider, log events.
    task automatic tick_cyc();
        logic [3:0] exp_dec;
        @(negedge clk);
        cyc++;
        exp_dec = 4'hF;
        if (prev_rd && exp_q.size() > 0) exp_dec = exp_q.pop_front();
        check("dec", o_dec, exp_dec);
        check("div_clk", o_div_clk, (cyc % TICK_DIV) == TICK_DIV - 1);
        prev_rd = o_rd;
        if (o_rd) rd_n++;
        if (cyc < 256) busy_log[cyc] = busy;
        if (gnt_a) begin
            ga_q.push_back(cyc);
            push_msg(msg_a);
            if (auto_drop) req_a = 1'b0;
        end
        if (gnt_b) begin
            gb_q.push_back(cyc);
            push_msg(msg_b);
            if (auto_drop) req_b = 1'b0;
        end
        if (o_clean) begin
            clean_n++;
            if (first_clean < 0) first_clean = cyc;
        end
        if (done) done_q.push_back(cyc);
    endtask

    task automatic run_to(input int last);
        while (cyc < last) tick_cyc();
    endtask

    initial begin
        // Single A message: burst, two full scroll wraps, clean until next tick, done.
        do_reset();
        msg_a = 12'h123;
        req_a = 1'b1;
        run_to(64);
        check("t1_gnt_a_cyc", q_at(ga_q, 0), 1);
        check("t1_gnt_a_n", ga_q.size(), 1);
        check("t1_gnt_b_n", gb_q.size(), 0);
        check("t1_rd_n", rd_n, 3);
        check("t1_digits_left", exp_q.size(), 0);
        check("t1_clean_first", first_clean, 56);
        check("t1_clean_n", clean_n, 4);
        check("t1_done_cyc", q_at(done_q, 0), 60);
        check("t1_done_n", done_q.size(), 1);
        check("t1_busy_c1", busy_log[1], 1);
        check("t1_busy_c59", busy_log[59], 1);
        check("t1_busy_c60", busy_log[60], 0);

        // Both requesting continuously: A, then B, then A again.
        do_reset();
        auto_drop = 1'b0;
        msg_a = 12'h123;
        msg_b = 12'h456;
        req_a = 1'b1;
        req_b = 1'b1;
        run_to(128);
        check("t3_gnt_a0", q_at(ga_q, 0), 1);
        check("t3_gnt_b0", q_at(gb_q, 0), 62);
        check("t3_gnt_a1", q_at(ga_q, 1), 122);
        check("t3_gnt_b_n", gb_q.size(), 1);
        check("t3_done0", q_at(done_q, 0), 60);
        check("t3_done1", q_at(done_q, 1), 120);
        check("t3_digits_left", exp_q.size(), 0);

        // Reset asserted during L1 clears outputs at once.
        do_reset();
        msg_a = 12'h789;
        req_a = 1'b1;
        tick_cyc();
        tick_cyc();
        check("t4_rd_l1", o_rd, 1);
        #2 rst = 1'b0;
        #1;
        check("t4_async_rd", o_rd, 0);
        check("t4_async_dec", o_dec, 4'hF);
        check("t4_async_busy", busy, 0);
        do_reset();
        run_to(12);
        check("t4_no_gnt_a", ga_q.size(), 0);
        check("t4_no_gnt_b", gb_q.size(), 0);
        check("t4_idle_busy", busy, 0);
        msg_b = 12'h456;
        req_b = 1'b1;
        run_to(16);
        check("t4_gnt_b_cyc", q_at(gb_q, 0), 13);

        // B scrolling, then A requests mid-SHOW.
        do_reset();
        msg_b = 12'h456;
        req_b = 1'b1;
        run_to(10);
        msg_a = 12'h123;
        req_a = 1'b1;
        run_to(70);
        check("t5_gnt_b_cyc", q_at(gb_q, 0), 1);
        check("t5_gnt_a_n", ga_q.size(), 1);
`ifdef PRIORITY_PREEMPT_EN
        check("t5_clean_first", first_clean, 11);
        check("t5_done_cyc", q_at(done_q, 0), 12);
        check("t5_gnt_a_cyc", q_at(ga_q, 0), 14);
`else
        check("t5_clean_first", first_clean, 56);
        check("t5_done_cyc", q_at(done_q, 0), 60);
        check("t5_gnt_a_cyc", q_at(ga_q, 0), 62);
`endif

        // A requests briefly during B's burst and withdraws: never served.
        do_reset();
        msg_b = 12'hABC;
        req_b = 1'b1;
        run_to(2);
        msg_a = 12'h321;
        req_a = 1'b1;
        run_to(3);
        req_a = 1'b0;
        run_to(70);
        check("t6_gnt_b_n", gb_q.size(), 1);
        check("t6_no_gnt_a", ga_q.size(), 0);
        check("t6_done_cyc", q_at(done_q, 0), 60);
        check("t6_busy_c61", busy_log[61], 0);
        check("t6_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
